// File: rtl/modulo_residual_sched.sv
// modulo_residual_sched: round-robin issue of channel differences to one shared modulo_residual unit, with credit-limited, in-order result buffering.
// Optional checker: define MODRES_SCHED_CHK_EN to add the err_sticky output.
module modulo_residual_sched #(
    parameter int WIDTH      = 16,
    parameter int NUM_CH     = 4,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH*WIDTH-1:0]   req_data,
    output logic [NUM_CH-1:0]         req_ready,
    output logic                      mr_valid_in,
    output logic [WIDTH-1:0]          mr_diff_in,
    input  logic                      mr_valid_out,
    input  logic [WIDTH-1:0]          mr_residual_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0] out_chan
`ifdef MODRES_SCHED_CHK_EN
    ,
    output logic                      err_sticky
`endif
);
    localparam int CHW = $clog2(NUM_CH);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + LAT + 1) + 1;

    logic [CHW-1:0]   rr_ptr;
    logic [LAT:1]     tag_v;
    logic [CHW-1:0]   tag_c [1:LAT];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [CHW-1:0]   mem_c [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fifo_count;
    logic [CW-1:0]    inflight;
    logic [CHW-1:0]   gnt_idx;
    logic             gnt_any, has_credit, issue, push, pop, full, wr_en;

    // Round-robin search starting at rr_ptr, first requester wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_any && req_valid[(int'(rr_ptr) + k) % NUM_CH]) begin
                gnt_any = 1'b1;
                gnt_idx = CHW'((int'(rr_ptr) + k) % NUM_CH);
            end
        end
    end

    // Number of issued operations still inside the shared unit
    always_comb begin
        inflight = '0;
        for (int s = 1; s <= LAT; s++) inflight = inflight + CW'(tag_v[s]);
    end

    // Credit comes only from registered state; a pop this cycle frees a slot next cycle
    assign has_credit  = (CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH);
    assign issue       = reset && gnt_any && has_credit;
    assign req_ready   = issue ? (NUM_CH'(1) << gnt_idx) : '0;
    assign mr_valid_in = issue;
    assign mr_diff_in  = req_data[gnt_idx*WIDTH +: WIDTH];

    // Results are accepted only when a matching tag reaches the last stage, so stale unit outputs after reset are dropped
    assign push      = mr_valid_out && tag_v[LAT];
    assign full      = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign out_valid = fifo_count != '0;
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && (!full || pop);
    assign out_data  = out_valid ? mem_d[rd_ptr] : '0;
    assign out_chan  = out_valid ? mem_c[rd_ptr] : '0;

    // Advance the round-robin pointer past each granted channel
    always_ff @(posedge clk) begin
        if (!reset)
            rr_ptr <= '0;
        else if (issue)
            rr_ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
    end

    // Channel tag pipeline matched to the unit latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_v <= '0;
            for (int s = 1; s <= LAT; s++) tag_c[s] <= '0;
        end else begin
            tag_v[1] <= issue;
            tag_c[1] <= gnt_idx;
            for (int s = 2; s <= LAT; s++) begin
                tag_v[s] <= tag_v[s-1];
                tag_c[s] <= tag_c[s-1];
            end
        end
    end

    // Result buffer storage; contents need no reset since out_valid masks them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_d[wr_ptr] <= mr_residual_out;
            mem_c[wr_ptr] <= tag_c[LAT];
        end
    end

    // Result buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(wr_en) - (AW+1)'(pop);
        end
    end

`ifdef MODRES_SCHED_CHK_EN
    localparam int QW = $clog2(LAT + 1);
    logic [QW-1:0] quiet;

    // Latch tag/result misalignment or overflow once the post-reset window has elapsed
    always_ff @(posedge clk) begin
        if (!reset) begin
            quiet      <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (quiet != QW'(LAT)) quiet <= quiet + 1'b1;
            if (quiet == QW'(LAT) && ((mr_valid_out != tag_v[LAT]) || (push && full && !pop)))
                err_sticky <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_modulo_residual_sched.sv
// tb_modulo_residual_sched: directed and random traffic checked against a queue model of issue order and credit.
module tb_modulo_residual_sched;
    localparam int W = 16, NC = 4, LAT = 2, FD = 4, LAMBDA = 10;

    logic          clk = 1'b0, reset = 1'b0, out_ready = 1'b0;
    logic [NC-1:0] req_valid = '0;
    logic [NC*W-1:0] req_data = '0;
    logic [NC-1:0] req_ready;
    logic          mr_valid_in, mr_valid_out, out_valid;
    logic [W-1:0]  mr_diff_in, mr_residual_out, out_data;
    logic [1:0]    out_chan;
`ifdef MODRES_SCHED_CHK_EN
    logic          err_sticky;
`endif

    typedef struct packed { logic [1:0] ch; logic [W-1:0] r; } ent_t;
    ent_t exp_q [$];
    int checks = 0, errors = 0;
    int rr = 0, outstanding = 0, dut_issues = 0, dut_pops = 0;
    logic [LAT-1:0] u_v;
    logic [W-1:0]   u_d [LAT];

    always #5 clk = ~clk;

    modulo_residual_sched #(.WIDTH(W), .NUM_CH(NC), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .mr_valid_in(mr_valid_in), .mr_diff_in(mr_diff_in), .mr_valid_out(mr_valid_out),
        .mr_residual_out(mr_residual_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan)
`ifdef MODRES_SCHED_CHK_EN
        , .err_sticky(err_sticky)
`endif
    );

    // Stand-in for modulo_residual: reduce modulo 2*LAMBDA into [-LAMBDA, LAMBDA)
    function automatic logic [W-1:0] resid(input logic [W-1:0] d);
        int r;
        r = int'($signed(d)) % (2 * LAMBDA);
        if (r >= LAMBDA) r -= 2 * LAMBDA;
        if (r < -LAMBDA) r += 2 * LAMBDA;
        return W'(r);
    endfunction

    // LAT-cycle shared unit pipeline
    always_ff @(posedge clk) begin
        if (!reset) u_v <= '0;
        else begin
            u_v[0] <= mr_valid_in;
            u_d[0] <= resid(mr_diff_in);
            for (int i = 1; i < LAT; i++) begin
                u_v[i] <= u_v[i-1];
                u_d[i] <= u_d[i-1];
            end
        end
    end
    assign mr_valid_out    = u_v[LAT-1];
    assign mr_residual_out = u_d[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; model grants from outstanding = issued - popped before this cycle
    task automatic cycle(input logic [NC-1:0] v, input logic [NC*W-1:0] d, input logic ordy);
        logic [NC-1:0] er;
        int g;
        ent_t e;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        @(negedge clk);
        er = '0;
        g  = -1;
        if (outstanding < FD)
            for (int k = 0; k < NC; k++)
                if (g < 0 && v[(rr + k) % NC]) g = (rr + k) % NC;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        check("mr_valid_in", 32'(mr_valid_in), 32'(g >= 0));
        if (g >= 0) check("mr_diff_in", 32'(mr_diff_in), 32'(d[g*W +: W]));
        if (mr_valid_in) dut_issues++;
        if (out_valid && ordy) begin
            dut_pops++;
            if (exp_q.size() == 0) check("out_valid_empty", 32'(out_valid), 32'(0));
            else begin
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e.r));
                check("out_chan", 32'(out_chan), 32'(e.ch));
                outstanding--;
            end
        end
        if (g >= 0) begin
            exp_q.push_back({2'(g), resid(d[g*W +: W])});
            rr = (g + 1) % NC;
            outstanding++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        reset     = 1'b0;
        req_valid = '1;
        req_data  = {$urandom, $urandom};
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_mr_valid_in", 32'(mr_valid_in), 32'(0));
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = '0;
        exp_q.delete();
        outstanding = 0;
        rr = 0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_chan", 32'(out_chan), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NC*W-1:0] d4;
        int n_iss, n_pop;
        repeat (2) @(posedge clk);
        #1;
        rst_pulse();

        cycle(4'b0001, 64'(16'd12), 1'b1);
        idle(LAT + 4);

        d4 = {-16'sd15, 16'sd12, -16'sd5, 16'sd3};
        repeat (24) cycle('1, d4, 1'b1);
        idle(LAT + FD + 2);

        n_iss = dut_issues;
        repeat (12) cycle(4'b0010, {4{16'd20}}, 1'b0);
        check("stall_issues", 32'(dut_issues - n_iss), 32'(FD));
        repeat (16) cycle(4'b0010, {4{16'd20}}, 1'b1);
        idle(LAT + FD + 2);

        n_iss = dut_issues;
        n_pop = dut_pops;
        for (int i = 0; i < 40; i++) cycle(4'b0100, {4{-16'sd25}}, i[0]);
        idle(LAT + FD + 4);
        check("ch2_in_eq_out", 32'(dut_issues - n_iss), 32'(dut_pops - n_pop));

        for (int i = 0; i < 2000; i++)
            cycle(NC'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) != 0);
        idle(LAT + FD + 4);

        repeat (3) cycle(4'b0001, {4{16'd7}}, 1'b0);
        cycle('0, '0, 1'b0);
        rst_pulse();
        for (int i = 0; i < 40; i++)
            cycle(NC'($urandom), {$urandom, $urandom}, 1'b1);
        idle(LAT + FD + 4);
        check("drained", 32'(exp_q.size()), 32'(0));
`ifdef MODRES_SCHED_CHK_EN
        check("err_sticky", 32'(err_sticky), 32'(0));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
